// File: rtl/exe_mem_skid_reg.sv
// EX->MEM pipeline register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. Control enables are forced low whenever no entry is valid.
module exe_mem_skid_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wb_en,
  input  logic                  in_mem_r_en,
  input  logic                  in_mem_w_en,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_wb_dest,
  input  logic [DATA_W-1:0]     in_val_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wb_en,
  output logic                  out_mem_r_en,
  output logic                  out_mem_w_en,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_wb_dest,
  output logic [DATA_W-1:0]     out_val_rm,
  output logic [1:0]            occupancy
);

  localparam int unsigned OCC_W = 2;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     val_rm;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t in_entry;

  assign in_entry = '{wb_en:      in_wb_en,
                      mem_r_en:   in_mem_r_en,
                      mem_w_en:   in_mem_w_en,
                      alu_result: in_alu_result,
                      wb_dest:    in_wb_dest,
                      val_rm:     in_val_rm};

  // State and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Next-state and storage update; flush only collapses state, data is kept
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            m_d     = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (out_ready) begin
            if (in_valid) m_d = in_entry;
            else          state_d = ST_EMPTY;
          end else if (in_valid) begin
            s_d     = in_entry;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            m_d     = s_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake and occupancy decoded from the state register only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = OCC_W'(0);
    unique case (state_q)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = OCC_W'(1);
      end
      ST_TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = OCC_W'(2);
      end
      default: ;
    endcase
  end

  assign out_wb_en      = m_q.wb_en    & out_valid;
  assign out_mem_r_en   = m_q.mem_r_en & out_valid;
  assign out_mem_w_en   = m_q.mem_w_en & out_valid;
  assign out_alu_result = m_q.alu_result;
  assign out_wb_dest    = m_q.wb_dest;
  assign out_val_rm     = m_q.val_rm;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Bench for exe_mem_skid_reg: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_exe_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en, in_mem_r_en, in_mem_w_en;
  logic [31:0] in_alu_result;
  logic [3:0]  in_wb_dest;
  logic [31:0] in_val_rm;
  logic        out_valid;
  logic        out_ready;
  logic        out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [31:0] out_alu_result;
  logic [3:0]  out_wb_dest;
  logic [31:0] out_val_rm;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;

  exe_mem_skid_reg #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_alu_result(in_alu_result), .in_wb_dest(in_wb_dest), .in_val_rm(in_val_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .out_alu_result(out_alu_result), .out_wb_dest(out_wb_dest), .out_val_rm(out_val_rm),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb, mr, mw;
    logic [31:0] alu;
    logic [3:0]  dest;
    logic [31:0] rm;
  } ent_t;

  // Model: a FIFO of at most two entries; the head is what MEM sees.
  ent_t q[$];
  ent_t m_mdl;
  ent_t cur_in;
  bit   mdl_push, mdl_pop;

  assign cur_in = '{in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_result, in_wb_dest, in_val_rm};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_mdl = '0;
    end else begin
      mdl_push = in_valid && (q.size() < 2);
      mdl_pop  = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (mdl_pop)  void'(q.pop_front());
        if (mdl_push) q.push_back(cur_in);
      end
      if (q.size() > 0) m_mdl = q[0];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    automatic bit v = q.size() > 0;
    check("mdl_out_valid", 64'(out_valid), 64'(v));
    check("mdl_in_ready",  64'(in_ready),  64'(q.size() < 2));
    check("mdl_occupancy", 64'(occupancy), 64'(q.size()));
    check("mdl_wb_en",     64'(out_wb_en),    64'(m_mdl.wb && v));
    check("mdl_mem_r_en",  64'(out_mem_r_en), 64'(m_mdl.mr && v));
    check("mdl_mem_w_en",  64'(out_mem_w_en), 64'(m_mdl.mw && v));
    check("mdl_alu",       64'(out_alu_result), 64'(m_mdl.alu));
    check("mdl_dest",      64'(out_wb_dest),    64'(m_mdl.dest));
    check("mdl_rm",        64'(out_val_rm),     64'(m_mdl.rm));
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic v, input logic [31:0] alu, input logic wb, input logic mw);
    in_valid      = v;
    in_alu_result = alu;
    in_wb_en      = wb;
    in_mem_r_en   = 1'b0;
    in_mem_w_en   = mw;
    in_wb_dest    = alu[3:0];
    in_val_rm     = ~alu;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    put(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_occ",   64'(occupancy), 64'd0);
    check("rst_alu",   64'(out_alu_result), 64'd0);
    check("rst_ctrl",  64'({out_wb_en, out_mem_r_en, out_mem_w_en}), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_valid", 64'(out_valid), 64'd0);
    check("rel_rm",    64'(out_val_rm), 64'd0);
    put(1'b0, 32'd0, 1'b0, 1'b0);
    step();

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, 32'(i), 1'b1, 1'b0);
      step();
      check("stream_alu",   64'(out_alu_result), 64'(i));
      check("stream_ready", 64'(in_ready), 64'd1);
    end
    put(1'b0, 32'd0, 1'b0, 1'b0);
    step();
    check("stream_drain", 64'(occupancy), 64'd0);

    // Skid
    out_ready = 1'b0;
    put(1'b1, 32'h10, 1'b1, 1'b0);
    step();
    check("skid_occ1", 64'(occupancy), 64'd1);
    check("skid_alu1", 64'(out_alu_result), 64'h10);
    put(1'b1, 32'h20, 1'b1, 1'b0);
    step();
    check("skid_occ2",  64'(occupancy), 64'd2);
    check("skid_ready", 64'(in_ready), 64'd0);
    check("skid_alu2",  64'(out_alu_result), 64'h10);
    put(1'b0, 32'd0, 1'b0, 1'b0);
    step();
    check("skid_hold", 64'(out_alu_result), 64'h10);
    out_ready = 1'b1;
    step();
    check("skid_pop_b",  64'(out_alu_result), 64'h20);
    check("skid_ready1", 64'(in_ready), 64'd1);
    step();
    check("skid_empty", 64'(out_valid), 64'd0);

    // Bubble gating
    put(1'b1, 32'h77, 1'b1, 1'b1);
    step();
    check("bub_wb1", 64'({out_wb_en, out_mem_w_en}), 64'd3);
    put(1'b0, 32'd0, 1'b0, 1'b0);
    step();
    check("bub_valid", 64'(out_valid), 64'd0);
    check("bub_ctrl",  64'({out_wb_en, out_mem_w_en}), 64'd0);
    check("bub_alu",   64'(out_alu_result), 64'h77);

    // Flush in TWO with simultaneous input and out_ready
    out_ready = 1'b0;
    put(1'b1, 32'h41, 1'b0, 1'b0);
    step();
    put(1'b1, 32'h42, 1'b0, 1'b0);
    step();
    check("fl_two", 64'(occupancy), 64'd2);
    flush = 1'b1; out_ready = 1'b1;
    put(1'b1, 32'h99, 1'b1, 1'b1);
    step();
    check("fl_occ",   64'(occupancy), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_alu",   64'(out_alu_result), 64'h41);
    flush = 1'b0;
    put(1'b1, 32'h55, 1'b0, 1'b0);
    step();
    check("fl_next", 64'(out_alu_result), 64'h55);
    check("fl_occ1", 64'(occupancy), 64'd1);
    put(1'b0, 32'd0, 1'b0, 1'b0);
    step();

    // Async reset while holding two entries
    out_ready = 1'b0;
    put(1'b1, 32'h61, 1'b1, 1'b1);
    step();
    put(1'b1, 32'h62, 1'b1, 1'b1);
    step();
    put(1'b0, 32'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_occ",   64'(occupancy), 64'd0);
    check("ar_ready", 64'(in_ready), 64'd1);
    check("ar_alu",   64'(out_alu_result), 64'd0);
    check("ar_ctrl",  64'({out_wb_en, out_mem_w_en}), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_wb_en      = 1'($urandom);
      in_mem_r_en   = 1'($urandom);
      in_mem_w_en   = 1'($urandom);
      in_alu_result = $urandom;
      in_wb_dest    = 4'($urandom);
      in_val_rm     = $urandom;
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      step();
    end

    flush = 1'b0; in_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
